sa_scan_chain_ctrl: RTL and testbench

Sequencing controller for a serial scan chain built from scan flip-flops with asynchronous clear, as used in the small-config SA datapath. A requester hands over a parallel pattern. The block shifts it into the chain and optionally pulses a functional capture window. It then shifts the chain contents back out and returns them as a parallel response. It sits between the test/config host interface and the chain's scan_en/scan_in/scan_out pins.

---
 rtl/sa_scan_pkg.sv | 12 +
 rtl/sa_scan_shreg.sv | 36 +++
 rtl/sa_scan_chain_ctrl.sv | 138 +++++++++++++
 tb/tb_sa_scan_chain_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_scan_pkg.sv
// Shared types for the scan chain sequencing controller.
package sa_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_IN,
    ST_CAPTURE,
    ST_SHIFT_OUT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/sa_scan_shreg.sv
// Parallel-load shift register: serial-in at the MSB, shifts toward the LSB.
module sa_scan_shreg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CP,
  input  logic             CDN,
  input  logic             load,
  input  logic             shift,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = load_data;
    end else if (shift) begin
      data_d = {ser_in, data_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/sa_scan_chain_ctrl.sv
// Scan chain sequencer: shift a pattern in, optionally pulse capture, shift
// the chain back out and present it as a parallel response.
module sa_scan_chain_ctrl
  import sa_scan_pkg::*;
#(
  parameter int unsigned CHAIN_LEN  = 32,
  parameter int unsigned CAP_CYCLES = 1
) (
  input  logic                 CP,
  input  logic                 CDN,
  input  logic                 req_vld,
  output logic                 req_rdy,
  input  logic [CHAIN_LEN-1:0] req_pattern,
  input  logic                 req_capture,
  input  logic                 abort,
  output logic                 rsp_vld,
  input  logic                 rsp_rdy,
  output logic [CHAIN_LEN-1:0] rsp_data,
  output logic                 scan_en,
  output logic                 scan_in,
  input  logic                 scan_out,
  output logic                 busy
);

  localparam int unsigned CNT_MAX = (CAP_CYCLES > CHAIN_LEN) ? CAP_CYCLES : CHAIN_LEN;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cap_q, cap_d;
  logic               req_rdy_q, req_rdy_d;
  logic               pat_load;
  logic [CHAIN_LEN-1:0] pat_q;
  logic               pat_unused;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cap_d    = cap_q;
    pat_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_vld && req_rdy_q) begin
          state_d  = ST_SHIFT_IN;
          cnt_d    = CNT_W'(CHAIN_LEN);
          cap_d    = req_capture;
          pat_load = 1'b1;
        end
      end
      ST_SHIFT_IN: begin
        if (cnt_q == CNT_W'(1)) begin
          if (cap_q) begin
            state_d = ST_CAPTURE;
            cnt_d   = CNT_W'(CAP_CYCLES);
          end else begin
            state_d = ST_SHIFT_OUT;
            cnt_d   = CNT_W'(CHAIN_LEN);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_SHIFT_OUT;
          cnt_d   = CNT_W'(CHAIN_LEN);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SHIFT_OUT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_rdy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides whatever the state decode above chose.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
    // Registered ready keeps req_rdy low throughout reset and rises on the first edge after it.
    req_rdy_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cap_q     <= 1'b0;
      req_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cap_q     <= cap_d;
      req_rdy_q <= req_rdy_d;
    end
  end

  sa_scan_shreg #(.WIDTH(CHAIN_LEN)) u_pat (
    .CP        (CP),
    .CDN       (CDN),
    .load      (pat_load),
    .shift     (state_q == ST_SHIFT_IN),
    .ser_in    (1'b0),
    .load_data (req_pattern),
    .q         (pat_q)
  );

  sa_scan_shreg #(.WIDTH(CHAIN_LEN)) u_rsp (
    .CP        (CP),
    .CDN       (CDN),
    .load      (1'b0),
    .shift     (state_q == ST_SHIFT_OUT),
    .ser_in    (scan_out),
    .load_data ('0),
    .q         (rsp_data)
  );

  // Only the LSB of the pattern register drives the chain.
  assign pat_unused = ^pat_q[CHAIN_LEN-1:1];

  assign req_rdy = req_rdy_q;
  assign busy    = (state_q != ST_IDLE);
  assign rsp_vld = (state_q == ST_RESP);
  assign scan_en = (state_q == ST_SHIFT_IN) || (state_q == ST_SHIFT_OUT);
  assign scan_in = (state_q == ST_SHIFT_IN) && pat_q[0];

endmodule

// File: tb/tb_sa_scan_chain_ctrl.sv
// Directed bench for sa_scan_chain_ctrl with a behavioural scan chain model.
module tb_sa_scan_chain_ctrl;

  localparam int unsigned N = 32;
  localparam int unsigned C = 2;

  logic         CP = 1'b0;
  logic         CDN = 1'b0;
  logic         req_vld = 1'b0;
  logic         req_rdy;
  logic [N-1:0] req_pattern = '0;
  logic         req_capture = 1'b0;
  logic         abort = 1'b0;
  logic         rsp_vld;
  logic         rsp_rdy = 1'b0;
  logic [N-1:0] rsp_data;
  logic         scan_en;
  logic         scan_in;
  logic         scan_out;
  logic         busy;

  logic [N-1:0] chain;
  logic         prev_en;

  int checks = 0;
  int failures = 0;

  sa_scan_chain_ctrl #(.CHAIN_LEN(N), .CAP_CYCLES(C)) dut (
    .CP          (CP),
    .CDN         (CDN),
    .req_vld     (req_vld),
    .req_rdy     (req_rdy),
    .req_pattern (req_pattern),
    .req_capture (req_capture),
    .abort       (abort),
    .rsp_vld     (rsp_vld),
    .rsp_rdy     (rsp_rdy),
    .rsp_data    (rsp_data),
    .scan_en     (scan_en),
    .scan_in     (scan_in),
    .scan_out    (scan_out),
    .busy        (busy)
  );

  always #5 CP = ~CP;

  // Chain model: shifts toward chain[N-1]; first functional edge of a window loads ~contents.
  always @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      chain   <= '0;
      prev_en <= 1'b0;
    end else begin
      prev_en <= scan_en;
      if (scan_en) chain <= {chain[N-2:0], scan_in};
      else if (prev_en) chain <= ~chain;
    end
  end
  assign scan_out = chain[N-1];

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic start_req(input logic [N-1:0] p, input logic cap);
    @(negedge CP);
    req_pattern = p;
    req_capture = cap;
    req_vld     = 1'b1;
    tick();
    req_vld     = 1'b0;
  endtask

  // k = samples after the accept edge until rsp_vld (-1 on timeout).
  task automatic wait_vld(input logic [N-1:0] p, output int k, output int lo,
                          output int hi, output int sin_bad);
    k = 0; lo = 0; hi = 0; sin_bad = 0;
    while (rsp_vld !== 1'b1 && k < 300) begin
      if (scan_en === 1'b1) hi++; else lo++;
      if (k < N && scan_in !== p[k]) sin_bad++;
      tick();
      k++;
    end
    if (k >= 300) k = -1;
  endtask

  task automatic test_reset();
    CDN = 1'b0;
    req_vld = 1'b1;
    req_pattern = 32'h1357_9BDF;
    repeat (3) tick();
    checks++;
    if ({req_rdy, rsp_vld, scan_en, scan_in, busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got={rdy,vld,en,in,busy}=%b exp=00000",
               {req_rdy, rsp_vld, scan_en, scan_in, busy});
    end
    checks++;
    if (rsp_data !== '0) begin
      failures++;
      $display("FAIL reset_rsp_data got=%h exp=0", rsp_data);
    end
    req_vld = 1'b0;
    @(negedge CP);
    CDN = 1'b1;
    tick();
    checks++;
    if (req_rdy !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got rdy=%b busy=%b exp rdy=1 busy=0", req_rdy, busy);
    end
  endtask

  task automatic test_loopback();
    int k, lo, hi, sb;
    logic [N-1:0] p;
    p = 32'hA5C3_0F81;
    start_req(p, 1'b0);
    checks++;
    if (busy !== 1'b1 || req_rdy !== 1'b0) begin
      failures++;
      $display("FAIL loop_accept got busy=%b rdy=%b exp busy=1 rdy=0", busy, req_rdy);
    end
    wait_vld(p, k, lo, hi, sb);
    checks++;
    if (k !== 2 * N) begin
      failures++;
      $display("FAIL loop_latency got=%0d exp=%0d", k, 2 * N);
    end
    checks++;
    if (hi !== 2 * N || lo !== 0) begin
      failures++;
      $display("FAIL loop_scan_en got hi=%0d lo=%0d exp hi=%0d lo=0", hi, lo, 2 * N);
    end
    checks++;
    if (sb !== 0) begin
      failures++;
      $display("FAIL loop_scan_in got bad_bits=%0d exp=0", sb);
    end
    checks++;
    if (rsp_data !== p) begin
      failures++;
      $display("FAIL loop_rsp_data got=%h exp=%h", rsp_data, p);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    logic [N-1:0] exp_data;
    exp_data = 32'hA5C3_0F81;
    bad = 0;
    rsp_rdy = 1'b0;
    repeat (10) begin
      tick();
      if (rsp_vld !== 1'b1 || rsp_data !== exp_data || req_rdy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL bp_hold got bad_cycles=%0d exp=0", bad);
    end
    @(negedge CP);
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
    checks++;
    if (req_rdy !== 1'b1 || rsp_vld !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_release got rdy=%b vld=%b busy=%b exp 1 0 0", req_rdy, rsp_vld, busy);
    end
    checks++;
    if (rsp_data !== exp_data) begin
      failures++;
      $display("FAIL bp_data_kept got=%h exp=%h", rsp_data, exp_data);
    end
  endtask

  task automatic test_capture();
    int k, lo, hi, sb;
    logic [N-1:0] p;
    p = 32'h0000_FFFF;
    start_req(p, 1'b1);
    wait_vld(p, k, lo, hi, sb);
    checks++;
    if (k !== 2 * N + C) begin
      failures++;
      $display("FAIL cap_latency got=%0d exp=%0d", k, 2 * N + C);
    end
    checks++;
    if (lo !== C || hi !== 2 * N) begin
      failures++;
      $display("FAIL cap_scan_en got lo=%0d hi=%0d exp lo=%0d hi=%0d", lo, hi, C, 2 * N);
    end
    checks++;
    if (rsp_data !== 32'hFFFF_0000) begin
      failures++;
      $display("FAIL cap_rsp_data got=%h exp=ffff0000", rsp_data);
    end
    @(negedge CP);
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
  endtask

  task automatic test_abort();
    int k, lo, hi, sb;
    start_req(32'h5555_AAAA, 1'b0);
    repeat (4) tick();
    @(negedge CP);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({busy, scan_en, rsp_vld, req_rdy} !== 4'b0001) begin
      failures++;
      $display("FAIL abort_shift_in got={busy,en,vld,rdy}=%b exp=0001",
               {busy, scan_en, rsp_vld, req_rdy});
    end
    start_req(32'h1234_5678, 1'b0);
    wait_vld(32'h1234_5678, k, lo, hi, sb);
    checks++;
    if (k !== 2 * N || rsp_data !== 32'h1234_5678) begin
      failures++;
      $display("FAIL abort_recover1 got k=%0d data=%h exp k=%0d data=12345678", k, rsp_data, 2 * N);
    end
    @(negedge CP);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({busy, scan_en, rsp_vld, req_rdy} !== 4'b0001) begin
      failures++;
      $display("FAIL abort_resp got={busy,en,vld,rdy}=%b exp=0001",
               {busy, scan_en, rsp_vld, req_rdy});
    end
    start_req(32'hDEAD_BEEF, 1'b1);
    wait_vld(32'hDEAD_BEEF, k, lo, hi, sb);
    checks++;
    if (k !== 2 * N + C || rsp_data !== 32'h2152_4110) begin
      failures++;
      $display("FAIL abort_recover2 got k=%0d data=%h exp k=%0d data=21524110", k, rsp_data, 2 * N + C);
    end
    @(negedge CP);
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
  endtask

  task automatic test_async_reset();
    int seen;
    start_req(32'hCAFE_F00D, 1'b0);
    repeat (N + 5) tick();
    @(negedge CP);
    #2;
    CDN = 1'b0;
    #1;
    checks++;
    if ({req_rdy, rsp_vld, scan_en, scan_in, busy} !== 5'b0 || rsp_data !== '0) begin
      failures++;
      $display("FAIL async_clear got={rdy,vld,en,in,busy}=%b data=%h exp 00000 0",
               {req_rdy, rsp_vld, scan_en, scan_in, busy}, rsp_data);
    end
    tick();
    @(negedge CP);
    CDN = 1'b1;
    seen = 0;
    repeat (80) begin
      tick();
      if (rsp_vld !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL async_no_rsp got active_cycles=%0d exp=0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_backpressure();
    test_capture();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
